issue_ctrl: RTL
===============

Name: issue_ctrl

Overview:
- Single-entry decode-to-execute issue controller for the in-order RV64IM pipeline.
- Holds one decoded instruction and tracks pending register writes in a 32-bit scoreboard.
- Stalls on RAW/WAW hazards, serializes control-flow and system instructions, and releases the instruction to execute on a valid/ready handshake.

Parameters:
- REG_ID_WIDTH, 5, register index width
- NUM_REGS, 32, architectural integer registers (x0 never tracked)
- PAYLOAD_WIDTH, 128, opaque decoded bundle (opcode, func3, func7, imm, control bits) carried unchanged
- STALL_CNT_WIDTH, 32, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction available
- in_ready  out  1  controller can accept into hold register
- in_payload  in  PAYLOAD_WIDTH  decoded bundle
- in_rs1, in_rs2, in_rd  in  REG_ID_WIDTH  source/destination indices
- in_uses_rs1, in_uses_rs2  in  1  source actually read
- in_reg_write  in  1  instruction writes rd
- in_is_ctrl  in  1  branch/jal/jalr
- in_is_sys  in  1  ecall/ebreak
- issue_valid  out  1  held instruction issuable this cycle
- issue_ready  in  1  execute stage accepts
- issue_payload  out  PAYLOAD_WIDTH  registered bundle
- issue_rd  out  REG_ID_WIDTH  registered rd
- issue_reg_write  out  1  registered reg_write
- wb_valid  in  1  writeback retiring a register write
- wb_rd  in  REG_ID_WIDTH  register being written back
- resolve_valid  in  1  control-flow instruction resolved
- redirect  in  1  flush hold register (mispredict/trap); valid with resolve_valid or sys_done
- sys_done  in  1  system instruction completed
- busy_mask  out  NUM_REGS  scoreboard contents
- stall_cycles  out  STALL_CNT_WIDTH  hazard/serialization stall count

Behaviour:
- Reset values: hold_valid=0, scoreboard=0, state=RUN, stall_cycles=0, issue_payload/issue_rd/issue_reg_write=0. Outputs: in_ready=1, issue_valid=0.
- Hold register: loaded on in_valid && in_ready. Registered fields are driven directly, giving 1-cycle latency from accept to earliest issue.
- in_ready = !hold_valid || fire, where fire = issue_valid && issue_ready. Back-to-back issue at one instruction per cycle is required.
- Hazard: (uses_rs1 && sb[rs1]) || (uses_rs2 && sb[rs2]) || (reg_write && sb[rd]). Index 0 is never busy.
- issue_valid = hold_valid && state==RUN && !hazard && (!is_sys || scoreboard==0).
- On fire with reg_write && rd!=0, set sb[rd].
- On wb_valid, clear sb[wb_rd]. Clearing an already-clear bit is a no-op.
- Same cycle set and clear of the same rd: the set wins.
- States:
  - RUN: fire of a ctrl instruction -> WAIT_CTRL. Fire of a sys instruction -> WAIT_SYS.
  - WAIT_CTRL: on resolve_valid -> RUN. If redirect is also high, clear hold_valid.
  - WAIT_SYS: on sys_done -> RUN. If redirect is also high, clear hold_valid.
- In WAIT_CTRL and WAIT_SYS, one instruction may still be accepted into hold, but it cannot issue.
- A redirect that flushes hold blocks a same-cycle accept (in_ready=0 that cycle). The scoreboard is never flushed; in-flight writes still retire.
- stall_cycles increments when hold_valid && !issue_valid. It saturates at all-ones.
- Reset asserted mid-operation returns everything to reset values immediately. A pending hold is discarded.

Optional Feature:
- Macro: ISSUE_WB_BYPASS_EN.
- Defined: hazard evaluation masks the bit being cleared by the same-cycle wb_valid/wb_rd, so a dependent instruction issues in the writeback cycle.
- Undefined: hazard uses the registered scoreboard only, so the dependent issues one cycle after writeback.

Test Plan:
- Reset, then addi x5 (rd=5, reg_write) accepted with issue_ready=1 -> issue_valid in cycle 1, busy_mask=0x20 next cycle.
- Holding add x6,x5,x5 while sb[5]=1 -> issue_valid=0 and stall_cycles counts 1 per cycle. After wb_valid, wb_rd=5: issue on the next cycle (bypass off) or the same cycle (ISSUE_WB_BYPASS_EN).
- beq issued, following instruction held -> no issue until resolve_valid. With redirect=1, hold is dropped and in_ready=1 the next cycle.
- ecall held with sb[7]=1 -> not issued until wb_rd=7 clears the scoreboard. After fire, state WAIT_SYS until sys_done.
- Issue of rd=9 and wb_rd=9 in the same cycle -> busy_mask bit 9 remains 1.
- rst_n dropped mid-WAIT_CTRL with hold valid -> all outputs return to reset values asynchronously; busy_mask=0.

Source files
------------

// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : issue_ctrl
// Brief    : Single-entry decode-to-execute issue controller with a
//            register scoreboard and ctrl/sys serialization.
//            Optional macro ISSUE_WB_BYPASS_EN: hazard check ignores the
//            scoreboard bit being cleared by the same-cycle writeback.
// Revision : 1.0 - initial release
// ============================================================================
module issue_ctrl #(
    parameter int REG_ID_WIDTH    = 5,
    parameter int NUM_REGS        = 32,
    parameter int PAYLOAD_WIDTH   = 128,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PAYLOAD_WIDTH-1:0]   in_payload,
    input  logic [REG_ID_WIDTH-1:0]    in_rs1,
    input  logic [REG_ID_WIDTH-1:0]    in_rs2,
    input  logic [REG_ID_WIDTH-1:0]    in_rd,
    input  logic                       in_uses_rs1,
    input  logic                       in_uses_rs2,
    input  logic                       in_reg_write,
    input  logic                       in_is_ctrl,
    input  logic                       in_is_sys,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [PAYLOAD_WIDTH-1:0]   issue_payload,
    output logic [REG_ID_WIDTH-1:0]    issue_rd,
    output logic                       issue_reg_write,
    input  logic                       wb_valid,
    input  logic [REG_ID_WIDTH-1:0]    wb_rd,
    input  logic                       resolve_valid,
    input  logic                       redirect,
    input  logic                       sys_done,
    output logic [NUM_REGS-1:0]        busy_mask,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_WAIT_CTRL = 2'd1,
        S_WAIT_SYS  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_hold_valid;
    logic [REG_ID_WIDTH-1:0]     r_rs1;
    logic [REG_ID_WIDTH-1:0]     r_rs2;
    logic                        r_uses_rs1;
    logic                        r_uses_rs2;
    logic                        r_is_ctrl;
    logic                        r_is_sys;
    logic [NUM_REGS-1:0]         r_sb;
    logic [NUM_REGS-1:0]         w_sb_nxt;
    logic [NUM_REGS-1:0]         w_sb_haz;
    logic [NUM_REGS-1:0]         w_wb_clr;
    logic [NUM_REGS-1:0]         w_rd_set;
    logic [STALL_CNT_WIDTH-1:0]  r_stall;
    logic                        w_hazard;
    logic                        w_fire;
    logic                        w_accept;
    logic                        w_flush;

    localparam logic [NUM_REGS-1:0] c_ONE = NUM_REGS'(1);

    assign w_wb_clr = wb_valid ? (c_ONE << wb_rd) : '0;
    assign w_rd_set = (w_fire && issue_reg_write && (issue_rd != '0)) ? (c_ONE << issue_rd) : '0;
    // Set is applied after clear so a same-cycle issue of the same rd wins; x0 is never tracked.
    assign w_sb_nxt = ((r_sb & ~w_wb_clr) | w_rd_set) & ~c_ONE;

`ifdef ISSUE_WB_BYPASS_EN
    assign w_sb_haz = r_sb & ~w_wb_clr;
`else
    assign w_sb_haz = r_sb;
`endif

    assign w_hazard = (r_uses_rs1 && w_sb_haz[r_rs1]) ||
                      (r_uses_rs2 && w_sb_haz[r_rs2]) ||
                      (issue_reg_write && w_sb_haz[issue_rd]);

    assign issue_valid = r_hold_valid && (r_state == S_RUN) && !w_hazard &&
                         (!r_is_sys || (r_sb == '0));
    assign w_fire      = issue_valid && issue_ready;
    // A flush only happens in a wait state with hold occupied, where in_ready is already low.
    assign in_ready    = !r_hold_valid || w_fire;
    assign w_accept    = in_valid && in_ready;
    assign busy_mask   = r_sb;
    assign stall_cycles = r_stall;

    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_fire && r_is_ctrl) begin
                    w_state_nxt = S_WAIT_CTRL;
                end else if (w_fire && r_is_sys) begin
                    w_state_nxt = S_WAIT_SYS;
                end
            end
            S_WAIT_CTRL: begin
                if (resolve_valid) begin
                    w_state_nxt = S_RUN;
                    w_flush     = redirect && r_hold_valid;
                end
            end
            S_WAIT_SYS: begin
                if (sys_done) begin
                    w_state_nxt = S_RUN;
                    w_flush     = redirect && r_hold_valid;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_RUN;
            r_hold_valid    <= 1'b0;
            r_rs1           <= '0;
            r_rs2           <= '0;
            r_uses_rs1      <= 1'b0;
            r_uses_rs2      <= 1'b0;
            r_is_ctrl       <= 1'b0;
            r_is_sys        <= 1'b0;
            issue_payload   <= '0;
            issue_rd        <= '0;
            issue_reg_write <= 1'b0;
            r_sb            <= '0;
            r_stall         <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sb    <= w_sb_nxt;
            if (w_flush) begin
                r_hold_valid <= 1'b0;
            end else if (w_accept) begin
                r_hold_valid    <= 1'b1;
                r_rs1           <= in_rs1;
                r_rs2           <= in_rs2;
                r_uses_rs1      <= in_uses_rs1;
                r_uses_rs2      <= in_uses_rs2;
                r_is_ctrl       <= in_is_ctrl;
                r_is_sys        <= in_is_sys;
                issue_payload   <= in_payload;
                issue_rd        <= in_rd;
                issue_reg_write <= in_reg_write;
            end else if (w_fire) begin
                r_hold_valid <= 1'b0;
            end
            if (r_hold_valid && !issue_valid && (r_stall != '1)) begin
                r_stall <= r_stall + STALL_CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire
